// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
// Frame: start, DATA_BITS data bits LSB first, optional parity, stop bit(s).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Number of serial bit periods in one frame.
  function automatic int frame_bits(input int stop_bits, input bit parity_en);
    return 1 + DATA_BITS + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_divider.sv
// uart_baud_divider: free-running 0..CLKS_PER_BIT-1 counter that flags the
// last clock of each serial bit period. clear restarts the count at 0 so a
// newly accepted frame gets a full-width start bit.
module uart_baud_divider #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count;

  // Count clocks within a bit period, wrapping on the last one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = (count == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per accepted SEND onto TX.
// Optional odd parity bit after data bit 7 when UART_PARITY_EN is defined;
// the default build (macro undefined) sends no parity bit.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, READY=1, waiting for SEND
// ST_START  | driving start bit (0)
// ST_DATA   | driving data bit bit_idx, LSB first
// ST_PARITY | driving odd parity bit (UART_PARITY_EN only)
// ST_STOP   | driving stop level for STOP_BITS bit periods
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] DATA,
  input  logic       SEND,
  output logic       READY,
  output logic       DONE,
  output logic       TX
);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic [1:0] stop_cnt;
  logic       accept;
  logic       bit_end;
`ifdef UART_PARITY_EN
  logic       par_bit;
`endif

  // READY is only high in ST_IDLE, so this is the only way a frame starts.
  assign accept = SEND && READY;

  uart_baud_divider #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_divider (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (accept),
    .bit_end (bit_end)
  );

`ifdef UART_PARITY_EN
  // Odd parity of the byte captured on accept.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ~^DATA;
    end
  end
`endif

  // Frame sequencer: TX, READY and DONE are registered alongside the state so
  // each bit level appears on TX from the edge that enters its bit period.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      TX       <= IDLE_LEVEL;
      READY    <= 1'b1;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg    <= DATA;
            bit_idx  <= '0;
            stop_cnt <= '0;
            READY    <= 1'b0;
            TX       <= START_LEVEL;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            TX    <= shreg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              TX    <= par_bit;
              state <= ST_PARITY;
`else
              TX    <= STOP_LEVEL;
              state <= ST_STOP;
`endif
            end else begin
              // Next bit is shreg[1] before the shift lands.
              TX      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            TX    <= STOP_LEVEL;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt == 2'(STOP_BITS - 1)) begin
              stop_cnt <= '0;
              READY    <= 1'b1;
              DONE     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          TX    <= IDLE_LEVEL;
          READY <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Transmit end of the team's UART link; serialises one byte per request onto TX.
- Frame format matches the receiver exactly: start (0), 8 data bits LSB first, optional parity, stop (1).
- Runs on the shared link clock CLK at CLKS_PER_BIT × baud (default 5×).
- Sits between the byte-producing logic and the TX pin.

Parameters:
- CLKS_PER_BIT, 5, CLK cycles per serial bit; legal range ≥2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  link clock; all logic on posedge.
- nRST  input  1  asynchronous, active-low reset.
- DATA  input  8  byte to send; sampled only on accept.
- SEND  input  1  request; a frame is accepted on a posedge where SEND & READY.
- READY  output  1  high when idle and able to accept.
- DONE  output  1  one-cycle pulse when the last stop bit completes.
- TX  output  1  serial line, registered, idles high.

Behaviour:
- Reset values: TX=1, READY=1, DONE=0, state IDLE, all counters 0.
- Reset assertion mid-frame forces TX=1 immediately (asynchronous) and abandons the frame. No partial bits are resumed.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP. Transitions are taken only on bit-period end, i.e. divider == CLKS_PER_BIT-1.
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> PARITY/STOP after bit index 7.
  - PARITY -> STOP.
  - STOP -> IDLE after STOP_BITS periods.
- Accept:
  - DATA is latched into the shift register; READY drops in the cycle after the accept edge.
  - SEND while READY=0 is ignored. It is not queued.
  - DATA changes during a frame have no effect.
- Timing (accept edge = cycle 0):
  - TX=0 during cycles 1..CLKS_PER_BIT.
  - Data bit i occupies cycles 1+CLKS_PER_BIT*(i+1) .. CLKS_PER_BIT*(i+2).
  - Each bit is held exactly CLKS_PER_BIT cycles.
- Frame length N = 1 + 8 + P + STOP_BITS bits, where P=1 with the macro and 0 without.
- At cycle N*CLKS_PER_BIT + 1: READY=1 and DONE=1 for one cycle. TX stays 1.
- Back-to-back: SEND held high with a new DATA is accepted in that same cycle, so the next start bit begins the following cycle. This gives a zero idle gap beyond the stop bit(s).
- Divider: counts 0..CLKS_PER_BIT-1 and wraps. It is cleared on accept so the start bit is full-width.
- Bit index: 3 bits, 0..7, no wrap beyond 7 within a frame.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - PARITY state is inserted after data bit 7.
  - Parity bit = ~^DATA_latched (odd parity: data plus parity holds an odd number of ones).
  - Frame is 11 bits at STOP_BITS=1.
- Undefined:
  - No PARITY state; stop follows data bit 7.
  - Frame is 10 bits at STOP_BITS=1.
- Must be set consistently with the receiver's parity configuration.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1;
  - a function for frame length in bits.
- One natural sub-module, uart_baud_divider:
  - inputs: CLK, nRST, clear;
  - output: bit_end pulse;
  - parameter: CLKS_PER_BIT.
- The FSM, shift register, and parity live in uart_transmitter.

Test Plan:
- Reset, then idle 20 cycles -> TX=1, READY=1, DONE=0 throughout.
- Default parameters, parity on, SEND 1 cycle with DATA=0x A5:
  - TX bit sequence is 0,1,0,1,0,0,1,0,1,1,1; each bit 5 cycles; parity bit=1 (four ones).
  - DONE pulses at cycle 56; READY high from cycle 56.
- DATA=0x07, parity off -> 10-bit frame 0,1,1,1,0,0,0,0,0,1; DONE at cycle 51. Loop back into the receiver gives sample[9:2]=0x07 and OK rises.
- SEND held high, DATA 0x00 then 0xFF:
  - second start bit begins the cycle after the first DONE;
  - parity bits are 1 then 1 (0x00 has zero ones, 0xFF has eight ones);
  - SEND pulses during the first frame are ignored.
- Assert nRST at cycle 23 of a frame -> TX=1 within the same cycle, READY=1; the next SEND starts a clean frame.
- CLKS_PER_BIT=16, STOP_BITS=2, DATA=0x3C -> every bit is 16 cycles; the stop level is held 32 cycles before DONE.
